// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package load_store_unit_pkg;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StMergeWr,
    StWr,
    StDone
  } lsu_state_e;

  // Reserved size or an address not aligned to the access size.
  function automatic logic req_is_err(logic [1:0] size, logic [1:0] offset);
    return (size == 2'b11) ||
           ((size == SizeHalf) && offset[0]) ||
           ((size == SizeWord) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane extraction for loads and lane merge for sub-word stores.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  output logic [31:0] load_val,
  output logic [31:0] merged_word
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Offset 0 is the most significant lane.
  assign byte_sh = {~offset, 3'b000};
  assign half_sh = {~offset[1], 4'b0000};
  assign byte_v  = 8'(word >> byte_sh);
  assign half_v  = 16'(word >> half_sh);

  always_comb begin
    load_val    = word;
    merged_word = store_data;
    case (size)
      SizeByte: begin
        load_val    = {{24{sign_ext & byte_v[7]}}, byte_v};
        merged_word = (word & ~(32'h0000_00ff << byte_sh)) |
                      ({24'h0, store_data[7:0]} << byte_sh);
      end
      SizeHalf: begin
        load_val    = {{16{sign_ext & half_v[15]}}, half_v};
        merged_word = (word & ~(32'h0000_ffff << half_sh)) |
                      ({16'h0, store_data[15:0]} << half_sh);
      end
      default: begin
        load_val    = word;
        merged_word = store_data;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator: turns CPU load/store requests into word-aligned memory accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_read_data
);

  lsu_state_e        state_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sign_ext_q;
  logic [1:0]        offset_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       load_val;
  logic [31:0]       merged_word;

  // mem_wdata_q doubles as the latched store data until the merge overwrites it.
  lsu_lane_align u_lane_align (
    .word        (mem_read_data),
    .offset      (offset_q),
    .size        (size_q),
    .sign_ext    (sign_ext_q),
    .store_data  (mem_wdata_q),
    .load_val    (load_val),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      sign_ext_q    <= 1'b0;
      offset_q      <= 2'b00;
      err_q         <= 1'b0;
      rdata_q       <= 32'h0;
      mem_address_q <= '0;
      mem_wdata_q   <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            we_q          <= we;
            size_q        <= size;
            sign_ext_q    <= sign_ext;
            offset_q      <= addr[1:0];
            mem_address_q <= {addr[ADDR_W-1:2], 2'b00};
            mem_wdata_q   <= wdata;
            err_q         <= req_is_err(size, addr[1:0]);
            if (req_is_err(size, addr[1:0])) begin
              state_q <= StDone;
            end else if (we && (size == SizeWord)) begin
              state_q <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          if (we_q) begin
            mem_wdata_q <= merged_word;
            state_q     <= StMergeWr;
          end else begin
            rdata_q <= load_val;
            state_q <= StDone;
          end
        end
        StMergeWr, StWr: state_q <= StDone;
        StDone:          state_q <= StIdle;
        default:         state_q <= StIdle;
      endcase
    end
  end

  assign ready          = (state_q == StIdle);
  assign done           = (state_q == StDone);
  assign mem_read       = (state_q == StRd);
  assign mem_write      = (state_q == StWr) || (state_q == StMergeWr);
  assign err            = err_q;
  assign rdata          = rdata_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-addressed big-endian memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  wire  [31:0] mem_read_data;

  logic [31:0] mem [0:255];
  logic [7:0]  rb  [0:1023];
  logic [31:0] exp_rdata;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .we             (we),
    .size           (size),
    .sign_ext       (sign_ext),
    .addr           (addr),
    .wdata          (wdata),
    .ready          (ready),
    .done           (done),
    .err            (err),
    .rdata          (rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  assign mem_read_data = mem_read ? mem[mem_address[9:2]] : 32'bz;

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [9:0] a);
    logic [9:0] b;
    b = {a[9:2], 2'b00};
    return {rb[b], rb[b + 10'd1], rb[b + 10'd2], rb[b + 10'd3]};
  endfunction

  // One request: the model predicts latency, strobe counts, write word and load result.
  task automatic txn(input logic w, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd);
    int          n;
    int          lat;
    int          rd_c;
    int          wr_c;
    int          dcyc;
    logic        e;
    logic [31:0] v;
    logic [31:0] exp_word;
    logic [31:0] exp_addr;

    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e = (sz == 2'd3) || ((a % n) != 0);
    if (e) lat = 1;
    else if (!w || sz == 2'd2) lat = 2;
    else lat = 3;
    exp_addr = {a[31:2], 2'b00};
    exp_word = 32'h0;
    if (!e && !w) begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v = (v << 8) | {24'h0, rb[10'(a + k)]};
      if (sx && n < 4 && v[8*n-1]) v = v | (32'hffff_ffff << (8 * n));
      exp_rdata = v;
    end
    if (!e && w) begin
      for (int k = 0; k < n; k++) rb[10'(a + k)] = 8'(wd >> (8 * (n - 1 - k)));
      exp_word = word_at(a[9:0]);
    end

    @(negedge clk);
    check("ready_idle", {31'h0, ready}, 32'h1);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    @(posedge clk);
    // req stays high through the busy cycles and must not be re-accepted.
    rd_c = 0; wr_c = 0; dcyc = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_read) begin
        rd_c++;
        check("rd_addr", mem_address, exp_addr);
      end
      if (mem_write) begin
        wr_c++;
        check("wr_addr", mem_address, exp_addr);
        check("wr_data", mem_write_data, exp_word);
      end
      if (done) begin
        dcyc = c;
        break;
      end
    end
    req = 1'b0;
    check("done_cycle", 32'(dcyc), 32'(lat));
    check("err", {31'h0, err}, {31'h0, e});
    check("rdata", rdata, exp_rdata);
    check("rd_count", 32'(rd_c), (e || (w && sz == 2'd2)) ? 32'd0 : 32'd1);
    check("wr_count", 32'(wr_c), (e || !w) ? 32'd0 : 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 256; i++) begin
      r = (i == 64) ? 32'h8811_2233 : $urandom;
      mem[i] = r;
      for (int k = 0; k < 4; k++) rb[4*i + k] = 8'(r >> (24 - 8 * k));
    end
    exp_rdata = 32'h0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, ready}, 32'h1);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_maddr", mem_address, 32'h0);
    check("rst_mwdata", mem_write_data, 32'h0);
    check("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    rst_n = 1'b1;

    txn(1'b0, 2'd0, 1'b1, 32'h100, 32'h0);
    check("tp_lb_signed", rdata, 32'hffff_ff88);
    txn(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
    check("tp_lh_unsigned", rdata, 32'h0000_2233);
    txn(1'b0, 2'd1, 1'b1, 32'h100, 32'h0);
    check("tp_lh_signed", rdata, 32'hffff_8811);
    txn(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00ab);
    check("tp_sb_mem", mem[64], 32'h88ab_2233);
    txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    check("tp_lw_after_sb", rdata, 32'h88ab_2233);
    txn(1'b1, 2'd2, 1'b0, 32'h104, 32'hdead_beef);
    txn(1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
    check("tp_lw_readback", rdata, 32'hdead_beef);
    txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    txn(1'b1, 2'd1, 1'b0, 32'h101, 32'h1234_5678);
    txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);

    // Reset during RD of a byte store: no write, no done, memory untouched.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h102; wdata = 32'h0000_0055;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("rst_mid_in_rd", {31'h0, mem_read}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_ready", {31'h0, ready}, 32'h1);
    check("rst_mid_done", {31'h0, done}, 32'h0);
    check("rst_mid_wr", {31'h0, mem_write}, 32'h0);
    exp_rdata = 32'h0;
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_quiet", {30'h0, done, mem_write}, 32'h0);
    end
    check("rst_mid_mem", mem[64], word_at(10'h100));

    for (int i = 0; i < 200; i++) begin
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          32'h100 + 32'($urandom_range(0, 31)), $urandom);
    end
    for (int i = 64; i < 72; i++) check("final_mem", mem[i], word_at(10'(4 * i)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
